// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo
// Store-and-forward AXI-Stream packet buffer placed between the cipher
// core's master stream and the DMA S2MM channel. The upstream master does
// not stall, so incoming beats are held until their packet completes. Only
// whole packets are ever presented downstream. A packet that cannot fit is
// dropped whole.
//
// Ports:
//   pkt_fifo_clk    clock
//   pkt_fifo_reset  synchronous active-high reset
//   s_axis_*        upstream stream (valid/data/last in, ready out)
//   m_axis_*        downstream stream (valid/data/last out, ready in)
//   pkt_count       complete packets held
//   word_count      words held (committed + in-progress + output stages)
//   overflow        sticky, set on any drop
//   drop_count      dropped packets, saturating at 16'hFFFF
module axis_packet_fifo #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              pkt_fifo_clk,
    input  logic              pkt_fifo_reset,
    input  logic              s_axis_valid,
    input  logic [DATA_W-1:0] s_axis_data,
    input  logic              s_axis_last,
    output logic              s_axis_ready,
    output logic              m_axis_valid,
    output logic [DATA_W-1:0] m_axis_data,
    output logic              m_axis_last,
    input  logic              m_axis_ready,
    output logic [ADDR_W:0]   pkt_count,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic [15:0]       drop_count
);

    localparam logic STATE_ACCEPT = 1'b0;
    localparam logic STATE_DROP   = 1'b1;

    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W:0] mem [DEPTH];

    logic [ADDR_W:0] wrSpec_q, wrSpec_d;
    logic [ADDR_W:0] wrCommit_q, wrCommit_d;
    logic [ADDR_W:0] fetch_q, fetch_d;
    logic [ADDR_W:0] rd_q, rd_d;
    logic            state_q, state_d;
    logic            pfValid_q, pfValid_d;
    logic [DATA_W:0] pfData_q;
    logic            outValid_q, outValid_d;
    logic [DATA_W:0] outData_q, outData_d;
    logic [ADDR_W:0] pktCount_q, pktCount_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     dropCount_q, dropCount_d;

    logic [ADDR_W:0] used;
    logic            full;
    logic            beatIn;
    logic            wrAccept;
    logic            wrDrop;
    logic            commit;
    logic            xfer;
    logic            lastXfer;
    logic            outLoad;
    logic            ramRead;

    // Handshake decode. rd_q only advances when a word leaves the block, so
    // words sitting in the prefetch/output registers still count as used;
    // fetch_q is the separate RAM read pointer that feeds those registers.
    always_comb begin
        used     = wrSpec_q - rd_q;
        full     = (used == DEPTH_CNT);
        beatIn   = s_axis_valid & (state_q == STATE_ACCEPT);
        wrAccept = beatIn & ~full;
        wrDrop   = beatIn & full;
        commit   = wrAccept & s_axis_last;
        xfer     = outValid_q & m_axis_ready;
        lastXfer = xfer & outData_q[DATA_W];
        outLoad  = pfValid_q & (~outValid_q | xfer);
        // Only committed words are fetched; the prefetch slot must be free
        // or emptying this cycle so a stream flows at one beat per cycle.
        ramRead  = (fetch_q != wrCommit_q) & (~pfValid_q | outLoad);
    end

    // Next-state logic for pointers, write FSM, output pipeline and counters.
    always_comb begin
        wrSpec_d    = wrSpec_q;
        wrCommit_d  = wrCommit_q;
        state_d     = state_q;
        overflow_d  = overflow_q;
        dropCount_d = dropCount_q;
        pktCount_d  = pktCount_q;

        if (wrAccept) begin
            wrSpec_d = wrSpec_q + PTR_ONE;
            if (s_axis_last) begin
                wrCommit_d = wrSpec_q + PTR_ONE;
            end
        end else if (wrDrop) begin
            // Rewind discards the partial packet; a lost last beat ends it.
            wrSpec_d   = wrCommit_q;
            overflow_d = 1'b1;
            if (dropCount_q != 16'hFFFF) begin
                dropCount_d = dropCount_q + 16'd1;
            end
            if (!s_axis_last) begin
                state_d = STATE_DROP;
            end
        end

        if ((state_q == STATE_DROP) && s_axis_valid && s_axis_last) begin
            state_d = STATE_ACCEPT;
        end

        unique case ({commit, lastXfer})
            2'b10:   pktCount_d = pktCount_q + PTR_ONE;
            2'b01:   pktCount_d = pktCount_q - PTR_ONE;
            default: pktCount_d = pktCount_q;
        endcase

        fetch_d    = ramRead ? fetch_q + PTR_ONE : fetch_q;
        rd_d       = xfer ? rd_q + PTR_ONE : rd_q;
        pfValid_d  = ramRead | (pfValid_q & ~outLoad);
        outValid_d = outLoad | (outValid_q & ~xfer);
        outData_d  = outLoad ? pfData_q : outData_q;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge pkt_fifo_clk) begin
        if (pkt_fifo_reset) begin
            wrSpec_q    <= '0;
            wrCommit_q  <= '0;
            fetch_q     <= '0;
            rd_q        <= '0;
            state_q     <= STATE_ACCEPT;
            pfValid_q   <= 1'b0;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            pktCount_q  <= '0;
            overflow_q  <= 1'b0;
            dropCount_q <= '0;
        end else begin
            wrSpec_q    <= wrSpec_d;
            wrCommit_q  <= wrCommit_d;
            fetch_q     <= fetch_d;
            rd_q        <= rd_d;
            state_q     <= state_d;
            pfValid_q   <= pfValid_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            pktCount_q  <= pktCount_d;
            overflow_q  <= overflow_d;
            dropCount_q <= dropCount_d;
        end
    end

    // Storage RAM with synchronous read into the prefetch register. The read
    // address never aliases the write address because fetch_q trails
    // wr_spec by less than DEPTH whenever a write is allowed.
    always_ff @(posedge pkt_fifo_clk) begin
        if (wrAccept) begin
            mem[wrSpec_q[ADDR_W-1:0]] <= {s_axis_last, s_axis_data};
        end
        if (ramRead) begin
            pfData_q <= mem[fetch_q[ADDR_W-1:0]];
        end
    end

    assign s_axis_ready = (state_q == STATE_DROP) | ~full;
    assign m_axis_valid = outValid_q;
    assign m_axis_data  = outData_q[DATA_W-1:0];
    assign m_axis_last  = outData_q[DATA_W];
    assign pkt_count    = pktCount_q;
    assign word_count   = used;
    assign overflow     = overflow_q;
    assign drop_count   = dropCount_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb_axis_packet_fifo
// Self-checking bench for axis_packet_fifo. A packet-level reference model
// (queues of committed and in-progress words, plus a drop flag) predicts
// the ready flag, the counters and the order and content of delivered beats.
module tb_axis_packet_fifo;

    localparam int DEPTH  = 64;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              sValid;
    logic [DATA_W-1:0] sData;
    logic              sLast;
    logic              sReady;
    logic              mValid;
    logic [DATA_W-1:0] mData;
    logic              mLast;
    logic              mReady;
    logic [ADDR_W:0]   pktCount;
    logic [ADDR_W:0]   wordCount;
    logic              overflowFlag;
    logic [15:0]       dropCount;

    int total = 0;
    int bad   = 0;

    // Reference model state: committed words awaiting delivery, the packet
    // currently being received, and whether the rest of a packet is discarded.
    logic [DATA_W:0] expQ[$];
    logic [DATA_W:0] inProg[$];
    bit              dropping   = 0;
    int              modelPkts  = 0;
    int              modelDrops = 0;
    bit              modelOvf   = 0;
    bit              modelValid = 0;
    bit              prevStall  = 0;
    logic [DATA_W:0] prevData;

    axis_packet_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .pkt_fifo_clk  (clk),
        .pkt_fifo_reset(rst),
        .s_axis_valid  (sValid),
        .s_axis_data   (sData),
        .s_axis_last   (sLast),
        .s_axis_ready  (sReady),
        .m_axis_valid  (mValid),
        .m_axis_data   (mData),
        .m_axis_last   (mLast),
        .m_axis_ready  (mReady),
        .pkt_count     (pktCount),
        .word_count    (wordCount),
        .overflow      (overflowFlag),
        .drop_count    (dropCount)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: at the falling edge compare DUT state with the model,
    // drive the inputs for the coming rising edge, and advance the model.
    task automatic applyStimulus(input logic r, input logic sv, input logic [DATA_W-1:0] sd,
                                 input logic sl, input logic mr);
        logic [DATA_W:0] w;
        int              used;
        logic            expReady;
        @(negedge clk);
        if (modelValid) begin
            checkOutput("pkt_count", 64'(pktCount), 64'(modelPkts));
            checkOutput("word_count", 64'(wordCount), 64'(expQ.size() + inProg.size()));
            checkOutput("overflow", 64'(overflowFlag), 64'(modelOvf));
            checkOutput("drop_count", 64'(dropCount), 64'(modelDrops));
            if (prevStall) begin
                checkOutput("hold_valid", 64'(mValid), 64'd1);
                checkOutput("hold_data", 64'({mLast, mData}), 64'(prevData));
            end
            if (mValid && expQ.size() == 0) begin
                checkOutput("valid_uncommitted", 64'(mValid), 64'd0);
            end
        end
        rst    = r;
        sValid = sv;
        sData  = sd;
        sLast  = sl;
        mReady = mr;
        if (r) begin
            expQ.delete();
            inProg.delete();
            dropping   = 0;
            modelPkts  = 0;
            modelDrops = 0;
            modelOvf   = 0;
            prevStall  = 0;
            modelValid = 1;
        end else if (modelValid) begin
            used     = expQ.size() + inProg.size();
            expReady = dropping || (used < DEPTH);
            checkOutput("s_ready", 64'(sReady), 64'(expReady));
            prevStall = mValid && !mr;
            prevData  = {mLast, mData};
            if (mValid && mr && expQ.size() != 0) begin
                w = expQ.pop_front();
                checkOutput("m_data", 64'(mData), 64'(w[DATA_W-1:0]));
                checkOutput("m_last", 64'(mLast), 64'(w[DATA_W]));
                if (w[DATA_W]) modelPkts--;
            end
            if (sv) begin
                if (dropping) begin
                    if (sl) dropping = 0;
                end else if (used < DEPTH) begin
                    inProg.push_back({sl, sd});
                    if (sl) begin
                        foreach (inProg[i]) expQ.push_back(inProg[i]);
                        inProg.delete();
                        modelPkts++;
                    end
                end else begin
                    inProg.delete();
                    modelOvf = 1;
                    if (modelDrops < 65535) modelDrops++;
                    dropping = !sl;
                end
            end
        end
    endtask

    task automatic sendPacket(input int len, input logic [DATA_W-1:0] base, input bit toggle);
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b0, 1'b1, base + DATA_W'(i), (i == len - 1), toggle ? logic'(i % 2 == 0) : 1'b0);
        end
    endtask

    task automatic drainFifo(input bit toggle);
        int n = 0;
        while (expQ.size() != 0 && n < 400) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, toggle ? logic'(n % 2 == 0) : 1'b1);
            n++;
        end
        checkOutput("drain_done", 64'(expQ.size()), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    // Directed scenarios followed by a randomized phase.
    initial begin
        int pktLen;
        int pos;
        int mode;
        logic sv;
        logic mr;

        rst = 1'b0; sValid = 1'b0; sData = '0; sLast = 1'b0; mReady = 1'b0;

        // Reset held two cycles with upstream active.
        applyStimulus(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hBEEF, 1'b0, 1'b0);
        checkOutput("rst_m_valid", 64'(mValid), 64'd0);
        checkOutput("rst_m_data", 64'(mData), 64'd0);
        checkOutput("rst_m_last", 64'(mLast), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("rst_s_ready", 64'(sReady), 64'd1);

        // Single 16-word packet: first beat two edges after the last input.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h1000 + 32'(i), (i == 15), 1'b1);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("lat_e1", 64'(mValid), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("lat_e2", 64'(mValid), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("lat_e3", 64'(mValid), 64'd1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
            checkOutput("stream_valid", 64'(mValid), 64'd1);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("stream_end", 64'(mValid), 64'd0);

        // Cut-off: an unfinished packet is never presented.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h2000 + 32'(i), 1'b0, 1'b1);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        end
        checkOutput("cut_valid", 64'(mValid), 64'd0);
        checkOutput("cut_words", 64'(wordCount), 64'd15);
        applyStimulus(1'b0, 1'b1, 32'h200F, 1'b1, 1'b1);
        drainFifo(1'b0);

        // Backpressure with ready toggling.
        sendPacket(8, 32'h3000, 1'b1);
        sendPacket(4, 32'h3100, 1'b1);
        drainFifo(1'b1);

        // Overflow: 60 committed words, then a 6-word packet ignoring ready.
        for (int p = 0; p < 6; p++) sendPacket(10, 32'h4000 + 32'(p * 16), 1'b0);
        sendPacket(6, 32'h4800, 1'b0);
        checkOutput("ovf_words", 64'(wordCount), 64'd60);
        checkOutput("ovf_flag", 64'(overflowFlag), 64'd1);
        checkOutput("ovf_drops", 64'(dropCount), 64'd1);
        drainFifo(1'b0);
        sendPacket(3, 32'h4900, 1'b0);
        drainFifo(1'b0);

        // Oversize packet into an empty FIFO, then an exactly-full packet.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 65; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h5000 + 32'(i), (i == 64), 1'b1);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("over_words", 64'(wordCount), 64'd0);
        checkOutput("over_pkts", 64'(pktCount), 64'd0);
        checkOutput("over_drops", 64'(dropCount), 64'd1);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h6000 + 32'(i), (i == 63), 1'b1);
        end
        checkOutput("full_pkts", 64'(expQ.size()), 64'd64);
        drainFifo(1'b0);

        // Randomized traffic; upstream never waits for ready.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        pktLen = 1 + $urandom_range(0, 23);
        pos    = 0;
        mode   = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c % 64 == 0) mode = $urandom_range(0, 2);
            sv = ($urandom_range(0, 3) != 0);
            mr = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : logic'($urandom_range(0, 1));
            applyStimulus(1'b0, sv, $urandom, sv && (pos == pktLen - 1), mr);
            if (sv) begin
                pos++;
                if (pos == pktLen) begin
                    pos    = 0;
                    pktLen = ($urandom_range(0, 15) == 0) ? 70 : 1 + $urandom_range(0, 23);
                end
            end
        end
        while (pos != 0) begin
            applyStimulus(1'b0, 1'b1, $urandom, (pos == pktLen - 1), 1'b1);
            pos = (pos == pktLen - 1) ? 0 : pos + 1;
        end
        drainFifo(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
